// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential imem reads, buffers returned words
// with their PCs in an in-order FIFO and hands them to decode; branches redirect.
module fetch_stage #(
    parameter int unsigned         PC_WIDTH   = 12,
    parameter int unsigned         INST_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned         BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  validD,
    output logic [INST_WIDTH-1:0] instD,
    output logic [PC_WIDTH-1:0]   pcD,
    input  logic                  stallD,
    input  logic                  branchD,
    input  logic [PC_WIDTH-1:0]   PC_branch
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(BUF_DEPTH);
    localparam logic [CW-1:0] FULL       = CW'(BUF_DEPTH);

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    entry_t              fifo_q [BUF_DEPTH];
    logic [PC_WIDTH-1:0] tag_q  [BUF_DEPTH];

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       tag_rd_q, tag_rd_d;
    logic [AW-1:0]       tag_wr_q, tag_wr_d;

    logic                pop;
    logic                push;
    logic                accept;
    logic                rsp_v;
    logic [CW:0]         credit_used;
    entry_t              head;

    // A pop this cycle frees its slot in time for the response of a request
    // issued now, which is what sustains one instruction per cycle at depth 2.
    always_comb begin
        pop         = (count_q != '0) && !stallD;
        credit_used = {1'b0, count_q} + {1'b0, outstanding_q} - (CW + 1)'(pop);
        imem_req    = !reset && (credit_used < CREDIT_MAX);
        imem_addr   = fetch_pc_q;
        accept      = imem_req && imem_ready;
        rsp_v       = imem_rvalid && (outstanding_q != '0);
        push        = rsp_v && (drop_cnt_q == '0) && !branchD;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_v);
        drop_cnt_d    = drop_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        tag_rd_d      = tag_rd_q + AW'(rsp_v);
        tag_wr_d      = tag_wr_q + AW'(accept);

        if (branchD) begin
            fetch_pc_d = PC_branch;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt_d = outstanding_d;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            if (rsp_v && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            assert (!(push && !pop && (count_q == FULL)));
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: tag_q[tag_rd_q], inst: imem_rdata};
        end
    end

    always_comb begin
        head   = fifo_q[rd_ptr_q];
        validD = (count_q != '0);
        instD  = validD ? head.inst : '0;
        pcD    = validD ? head.pc   : '0;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural imem with variable latency,
// a response scoreboard, a vector table of redirect scenarios and hand sequences.
module tb_fetch_stage;

    localparam int PW    = 12;
    localparam int IW    = 16;
    localparam int DEPTH = 2;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          validD;
    logic [IW-1:0] instD;
    logic [PW-1:0] pcD;
    logic          stallD;
    logic          branchD;
    logic [PW-1:0] PC_branch;

    fetch_stage #(
        .PC_WIDTH  (PW),
        .INST_WIDTH(IW),
        .RESET_PC  (12'h000),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .validD     (validD),
        .instD      (instD),
        .pcD        (pcD),
        .stallD     (stallD),
        .branchD    (branchD),
        .PC_branch  (PC_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] addr;
        int            due;
        bit            stale;
    } req_t;

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] inst;
    } exp_t;

    typedef struct {
        logic [PW-1:0] start;
        int            n;
        int            lat;
        bit            toggle;
        logic [PW-1:0] exp_first;
        logic [PW-1:0] exp_last;
    } vec_t;

    req_t          mq[$];
    exp_t          sb[$];
    logic [PW-1:0] got_pcs[$];

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            lat = 1;
    bit            ready_toggle = 1'b0;
    bit            ready_phase = 1'b1;
    int            consumed = 0;
    logic [PW-1:0] exp_fetch = '0;
    bit            prev_pending = 1'b0;
    logic [PW-1:0] prev_addr = '0;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        logic [3:0] hi;
        hi = a[3:0] ^ 4'h5;
        return {hi, a};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string nm, output int k);
        k = 0;
        while (!validD && k < 50) begin
            step(1);
            k++;
        end
        check(nm, {31'b0, validD}, 32'd1);
    endtask

    // Memory driver: presents at most one in-order response per cycle.
    initial begin
        req_t r;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            imem_ready  = ready_toggle ? ready_phase : 1'b1;
            ready_phase = ~ready_phase;
            imem_rvalid = 1'b0;
            imem_rdata  = IW'($urandom);
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                r           = mq.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(r.addr);
                if (!r.stale) sb.push_back('{r.addr, mem_word(r.addr)});
            end
        end
    end

    // Mid-cycle monitor: request ordering, consumption against the scoreboard,
    // and branch bookkeeping (stale marking, buffer flush).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                sb.delete();
                exp_fetch    = 12'h000;
                prev_pending = 1'b0;
                continue;
            end
            if (prev_pending && imem_req) check("addr_stable", imem_addr, prev_addr);
            if (imem_req && imem_ready) begin
                check("fetch_addr", imem_addr, exp_fetch);
                mq.push_back('{imem_addr, cyc + lat, 1'b0});
                exp_fetch = exp_fetch + 1'b1;
            end
            prev_pending = imem_req && !imem_ready && !branchD;
            prev_addr    = imem_addr;
            if (validD && !stallD) begin
                if (sb.size() == 0) begin
                    check("unexpected_instr_pc", pcD, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("instr_pc", pcD, e.pc);
                    check("instr_word", instD, e.inst);
                end
                consumed++;
                got_pcs.push_back(pcD);
            end
            if (!validD) check("idle_outputs_zero", {pcD, instD}, 32'd0);
            if (branchD) begin
                sb.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
                exp_fetch = PC_branch;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running, required finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        vec_t          vecs[4];
        int            k;
        int            c0;
        logic [PW-1:0] hold_pc;
        logic [IW-1:0] hold_inst;

        // Redirect scenarios: the last presented PC wraps at 12 bits.
        vecs[0] = '{12'hFFE, 4, 1, 1'b0, 12'hFFE, 12'h001};
        vecs[1] = '{12'h080, 6, 3, 1'b0, 12'h080, 12'h085};
        vecs[2] = '{12'h7F0, 5, 2, 1'b1, 12'h7F0, 12'h7F4};
        vecs[3] = '{12'h123, 3, 1, 1'b1, 12'h123, 12'h125};

        reset     = 1'b1;
        stallD    = 1'b0;
        branchD   = 1'b0;
        PC_branch = '0;
        step(3);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, validD}, 32'd0);
        check("rst_inst", instD, 32'd0);
        check("rst_pc", pcD, 32'd0);

        reset = 1'b0;
        #1;
        check("req_after_reset", {31'b0, imem_req}, 32'd1);
        check("addr_after_reset", imem_addr, 32'h000);
        // Accept in cycle 0, response in cycle 1, validD in cycle 2.
        wait_valid("first_valid_timeout", k);
        check("first_valid_latency", k, 32'd2);
        check("first_pc", pcD, 32'h000);

        c0 = consumed;
        step(8);
        check("throughput_8_cycles", consumed - c0, 32'd8);

        stallD    = 1'b1;
        hold_pc   = pcD;
        hold_inst = instD;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall_hold_pc", pcD, hold_pc);
            check("stall_hold_inst", instD, hold_inst);
        end
        check("stall_full_req_low", {31'b0, imem_req}, 32'd0);
        check("stall_valid", {31'b0, validD}, 32'd1);
        stallD = 1'b0;
        step(6);

        ready_toggle = 1'b1;
        step(16);
        ready_toggle = 1'b0;
        step(4);

        // Long latency: redirect with two stale requests in flight.
        reset = 1'b1;
        lat   = 3;
        step(2);
        reset = 1'b0;
        k = 0;
        while (mq.size() < 2 && k < 20) begin
            step(1);
            k++;
        end
        check("two_in_flight", mq.size(), 32'd2);
        branchD   = 1'b1;
        PC_branch = 12'h080;
        step(1);
        branchD = 1'b0;
        got_pcs.delete();
        check("valid_low_after_branch_l3", {31'b0, validD}, 32'd0);
        wait_valid("redirect_l3_timeout", k);
        check("redirect_l3_first_pc", pcD, 32'h080);
        k = 0;
        while (got_pcs.size() < 2 && k < 50) begin
            step(1);
            k++;
        end
        check("redirect_l3_count", got_pcs.size() >= 2, 32'd1);
        if (got_pcs.size() >= 2) check("redirect_l3_second_pc", got_pcs[1], 32'h081);

        // Branch colliding with a response and a pop in the same cycle.
        lat = 1;
        step(8);
        k = 0;
        do begin
            step(1);
            #1;
            k++;
        end while (!(imem_rvalid && validD) && k < 50);
        check("collision_setup", {31'b0, imem_rvalid && validD}, 32'd1);
        c0        = consumed;
        branchD   = 1'b1;
        PC_branch = 12'h200;
        step(1);
        branchD = 1'b0;
        got_pcs.delete();
        check("branch_pop_completes", consumed - c0, 32'd1);
        check("valid_low_after_branch", {31'b0, validD}, 32'd0);
        check("req_after_branch", {31'b0, imem_req}, 32'd1);
        check("addr_after_branch", imem_addr, 32'h200);
        wait_valid("redirect_timeout", k);
        check("redirect_latency", k, 32'd2);
        check("redirect_first_pc", pcD, 32'h200);
        step(4);

        for (int v = 0; v < 4; v++) begin
            lat          = vecs[v].lat;
            ready_toggle = vecs[v].toggle;
            branchD      = 1'b1;
            PC_branch    = vecs[v].start;
            step(1);
            branchD = 1'b0;
            got_pcs.delete();
            k = 0;
            while (got_pcs.size() < vecs[v].n && k < 200) begin
                step(1);
                k++;
            end
            check("vec_count", got_pcs.size() >= vecs[v].n, 32'd1);
            if (got_pcs.size() >= vecs[v].n) begin
                check("vec_first_pc", got_pcs[0], vecs[v].exp_first);
                check("vec_last_pc", got_pcs[vecs[v].n - 1], vecs[v].exp_last);
            end
        end
        ready_toggle = 1'b0;
        step(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
